// File: rtl/jk_pkg.sv
// jk_pkg: shared definitions for the JK command sequencer.
// Holds op encodings, FSM state type and the op-to-{j,k} mapping.
package jk_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_RST  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_TGL  = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   // Returns {j,k} for a command op.
   function automatic logic [1:0] op2jk(input logic [1:0] op);
      logic [1:0] jk;
      case (op)
         OP_HOLD: jk = 2'b00;
         OP_RST:  jk = 2'b01;
         OP_SET:  jk = 2'b10;
         default: jk = 2'b11;
      endcase
      return jk;
   endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: synchronous command FIFO, DEPTH entries of W bits.
// Ports: clk, rst, push/din, pop/dout (head, combinational), full, empty.
module jk_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);

   // Extra pointer MSB tells a full FIFO apart from an empty one.
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + ONE;
         if (do_pop)  rptr <= rptr + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues JK commands and drives j/k for rpt+1 cycles.
// Ports: cmd_* handshake in, j/k out, q_fb/q_exp/mismatch check, busy, issued_cnt.
module jk_cmd_sequencer
   import jk_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int RPT_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [RPT_W-1:0] cmd_rpt,
   output logic             j,
   output logic             k,
   input  logic             q_fb,
   output logic             q_exp,
   output logic             mismatch,
   input  logic             err_clr,
   output logic             busy,
   output logic [CNT_W-1:0] issued_cnt
);

   localparam int W = 2 + RPT_W;

   state_t           state, state_n;
   logic [RPT_W-1:0] rcnt, rcnt_n;
   logic [1:0]       jk_n;
   logic             pop;
   logic             cnt_en;
   logic             full;
   logic             empty;
   logic [W-1:0]     head;
   logic [1:0]       head_op;
   logic [RPT_W-1:0] head_rpt;

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid),
      .din   ({cmd_op, cmd_rpt}),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign head_op   = head[RPT_W +: 2];
   assign head_rpt  = head[RPT_W-1:0];
   assign cmd_ready = !full;
   assign busy      = (state == ISSUE) || !empty;

   always_comb begin
      state_n = state;
      rcnt_n  = rcnt;
      jk_n    = {j, k};
      pop     = 1'b0;
      cnt_en  = 1'b0;
      case (state)
         IDLE: begin
            jk_n = 2'b00;
            if (!empty) begin
               pop     = 1'b1;
               jk_n    = op2jk(head_op);
               rcnt_n  = head_rpt;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            cnt_en = 1'b1;
            if (rcnt != '0) begin
               rcnt_n = rcnt - RPT_W'(1);
            end else if (!empty) begin
               // Chain the next command with no idle cycle.
               pop    = 1'b1;
               jk_n   = op2jk(head_op);
               rcnt_n = head_rpt;
            end else begin
               jk_n    = 2'b00;
               state_n = IDLE;
            end
         end
         default: begin
            jk_n    = 2'b00;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rcnt       <= '0;
         j          <= 1'b0;
         k          <= 1'b0;
         issued_cnt <= '0;
      end else begin
         state <= state_n;
         rcnt  <= rcnt_n;
         j     <= jk_n[1];
         k     <= jk_n[0];
         if (cnt_en) issued_cnt <= issued_cnt + CNT_W'(1);
      end
   end

   // Shadow of the driven flop, fed by the same registered j/k.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_exp <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q_exp <= 1'b0;
            2'b10:   q_exp <= 1'b1;
            2'b11:   q_exp <= ~q_exp;
            default: q_exp <= q_exp;
         endcase
      end
   end

   // A fresh difference beats a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch <= 1'b0;
      end else if (q_fb != q_exp) begin
         mismatch <= 1'b1;
      end else if (err_clr) begin
         mismatch <= 1'b0;
      end
   end

endmodule
